// File: rtl/multsigned_booth_seq.sv
// Sequential radix-2 Booth signed multiplier controller.
// It shares one external ADD_W-bit combinational adder over WIDTH+1 cycles per product.
module multsigned_booth_seq #(
   parameter  int WIDTH = 17,
   localparam int ADD_W = WIDTH + 1
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               in_valid_i,
   output logic               in_ready_o,
   input  logic [WIDTH-1:0]   a_i,
   input  logic [WIDTH-1:0]   b_i,
   output logic               res_valid_o,
   input  logic               res_ready_i,
   output logic [2*WIDTH-1:0] res_o,
   output logic               busy_o,
   output logic [ADD_W-1:0]   add_in_0_o,
   output logic [ADD_W-1:0]   add_in_1_o,
   input  logic [ADD_W-1:0]   add_out_i,
   output logic [1:0]         state_o
);

   // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
   // a producer holds valid and its data stable until that edge.

   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      NEG  = 2'd1,
      RUN  = 2'd2,
      DONE = 2'd3
   } state_e;

   state_e            state_q, state_d;
   logic [ADD_W-1:0]  m_q, m_d;
   logic [ADD_W-1:0]  mn_q, mn_d;
   logic [ADD_W-1:0]  ph_q, ph_d;
   logic [WIDTH-1:0]  pl_q, pl_d;
   logic              q_q, q_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         m_q     <= '0;
         mn_q    <= '0;
         ph_q    <= '0;
         pl_q    <= '0;
         q_q     <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         m_q     <= m_d;
         mn_q    <= mn_d;
         ph_q    <= ph_d;
         pl_q    <= pl_d;
         q_q     <= q_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (in_valid_i) state_d = NEG;
         NEG:     state_d = RUN;
         RUN:     if (cnt_q == CNT_LAST) state_d = DONE;
         DONE:    if (res_ready_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      m_d   = m_q;
      mn_d  = mn_q;
      ph_d  = ph_q;
      pl_d  = pl_q;
      q_d   = q_q;
      cnt_d = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid_i) begin
               m_d   = {a_i[WIDTH-1], a_i};
               pl_d  = b_i;
               ph_d  = '0;
               q_d   = 1'b0;
               cnt_d = '0;
            end
         end
         NEG: mn_d = add_out_i;
         RUN: begin
            // Arithmetic shift of {PH,PL,Q} by one, taking the fresh sum as PH.
            ph_d  = {add_out_i[ADD_W-1], add_out_i[ADD_W-1:1]};
            pl_d  = {add_out_i[0], pl_q[WIDTH-1:1]};
            q_d   = pl_q[0];
            cnt_d = cnt_q + CNT_W'(1);
         end
         default: ;
      endcase
   end

   always_comb begin
      in_ready_o  = 1'b0;
      res_valid_o = 1'b0;
      add_in_0_o  = '0;
      add_in_1_o  = '0;
      unique case (state_q)
         IDLE: in_ready_o = 1'b1;
         NEG: begin
            add_in_0_o = ~m_q;
            add_in_1_o = ADD_W'(1);
         end
         RUN: begin
            add_in_0_o = ph_q;
            unique case ({pl_q[0], q_q})
               2'b01:   add_in_1_o = m_q;
               2'b10:   add_in_1_o = mn_q;
               default: add_in_1_o = '0;
            endcase
         end
         DONE: res_valid_o = 1'b1;
         default: ;
      endcase
   end

   assign busy_o  = (state_q != IDLE);
   assign res_o   = {ph_q[WIDTH-1:0], pl_q};
   assign state_o = state_q;

endmodule

// File: tb/tb_multsigned_booth_seq.sv
// Directed bench for multsigned_booth_seq at WIDTH=17, with a behavioural model of the
// external adder closing the add_in/add_out loop.
module tb_multsigned_booth_seq;

   localparam int W  = 17;
   localparam int AW = W + 1;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_NEG  = 2'd1;
   localparam logic [1:0] ST_RUN  = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            in_valid = 1'b0;
   logic            in_ready;
   logic [W-1:0]    a_in = '0;
   logic [W-1:0]    b_in = '0;
   logic            res_valid;
   logic            res_ready = 1'b0;
   logic [2*W-1:0]  res;
   logic            busy;
   logic [AW-1:0]   add_in_0;
   logic [AW-1:0]   add_in_1;
   logic [AW-1:0]   add_out;
   logic [1:0]      state;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   multsigned_booth_seq #(.WIDTH(W)) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .a_i         (a_in),
      .b_i         (b_in),
      .res_valid_o (res_valid),
      .res_ready_i (res_ready),
      .res_o       (res),
      .busy_o      (busy),
      .add_in_0_o  (add_in_0),
      .add_in_1_o  (add_in_1),
      .add_out_i   (add_out),
      .state_o     (state)
   );

   assign add_out = add_in_0 + add_in_1;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2*W-1:0] exp, input string name);
      int edges;
      a_in = a;
      b_in = b;
      in_valid = 1'b1;
      n_tests++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL %s accept: in_ready=%b expected 1", name, in_ready);
      end
      tick();
      in_valid = 1'b0;
      a_in = $urandom_range(0, (1 << W) - 1);
      b_in = $urandom_range(0, (1 << W) - 1);
      edges = 0;
      while (res_valid !== 1'b1 && edges < 40) begin
         tick();
         edges++;
      end
      n_tests++;
      if (edges !== W + 1) begin
         n_fail++;
         $display("FAIL %s latency: %0d edges expected %0d", name, edges, W + 1);
      end
      n_tests++;
      if (res !== exp) begin
         n_fail++;
         $display("FAIL %s result: res=%h expected %h", name, res, exp);
      end
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      n_tests++;
      if (res_valid !== 1'b0 || in_ready !== 1'b1 || state !== ST_IDLE) begin
         n_fail++;
         $display("FAIL %s handshake: res_valid=%b in_ready=%b state=%0d expected 0 1 0",
                  name, res_valid, in_ready, state);
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      #12;
      n_tests++;
      if (in_ready !== 1'b1 || res_valid !== 1'b0 || busy !== 1'b0 || res !== '0 ||
          add_in_0 !== '0 || add_in_1 !== '0 || state !== ST_IDLE) begin
         n_fail++;
         $display("FAIL reset: rdy=%b vld=%b busy=%b res=%h in0=%h in1=%h st=%0d expected 1 0 0 0 0 0 0",
                  in_ready, res_valid, busy, res, add_in_0, add_in_1, state);
      end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_directed;
      do_op(17'd3,     17'h1FFFB, 34'h3_FFFF_FFF1, "3x-5");
      do_op(17'h10000, 17'h10000, 34'h1_0000_0000, "min_x_min");
      do_op(17'd0,     17'h1FFFF, 34'h0,           "0x-1");
      do_op(17'h1FFFF, 17'h1FFFF, 34'h1,           "-1x-1");
      do_op(17'h0FFFF, 17'h0FFFF, 34'h0_FFFE_0001, "max_x_max");
      do_op(17'd100,   17'h1FF9C, 34'h3_FFFF_D8F0, "100x-100");
      do_op(17'd12345, 17'd2,     34'h0_0000_6072, "12345x2");
      do_op(17'h10000, 17'h0FFFF, 34'h3_0001_0000, "min_x_max");
   endtask

   task automatic test_adder_ports;
      n_tests++;
      if (add_in_0 !== '0 || add_in_1 !== '0) begin
         n_fail++;
         $display("FAIL adder_idle: in0=%h in1=%h expected 0 0", add_in_0, add_in_1);
      end
      a_in = 17'd3;
      b_in = 17'd6;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      n_tests++;
      if (state !== ST_NEG || add_in_0 !== 18'h3FFFC || add_in_1 !== 18'h00001) begin
         n_fail++;
         $display("FAIL adder_neg: st=%0d in0=%h in1=%h expected 1 3fffc 00001",
                  state, add_in_0, add_in_1);
      end
      tick();
      // First RUN step: b=6 gives {PL[0],Q}=00, so the adder sees PH=0 and 0.
      n_tests++;
      if (state !== ST_RUN || add_in_0 !== '0 || add_in_1 !== '0) begin
         n_fail++;
         $display("FAIL adder_run0: st=%0d in0=%h in1=%h expected 2 0 0",
                  state, add_in_0, add_in_1);
      end
      tick();
      // Second step: {PL[0],Q}=10, so the adder adds MN = -3.
      n_tests++;
      if (add_in_0 !== '0 || add_in_1 !== 18'h3FFFD) begin
         n_fail++;
         $display("FAIL adder_run1: in0=%h in1=%h expected 0 3fffd", add_in_0, add_in_1);
      end
      for (int i = 0; i < 40 && res_valid !== 1'b1; i++) tick();
      n_tests++;
      if (res !== 34'h0_0000_0012) begin
         n_fail++;
         $display("FAIL adder_result: res=%h expected 0000000012", res);
      end
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
   endtask

   task automatic test_backpressure;
      a_in = 17'h1FFFD;
      b_in = 17'd11;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 40 && res_valid !== 1'b1; i++) tick();
      for (int i = 0; i < 10; i++) begin
         in_valid = i[0];
         a_in = 17'd5;
         b_in = 17'd5;
         n_tests++;
         if (res_valid !== 1'b1 || res !== 34'h3_FFFF_FFDF || in_ready !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL hold[%0d]: vld=%b res=%h rdy=%b busy=%b expected 1 3ffffffdf 0 1",
                     i, res_valid, res, in_ready, busy);
         end
         tick();
      end
      in_valid = 1'b0;
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      tick();
      n_tests++;
      if (state !== ST_IDLE || res_valid !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL hold_release: st=%0d vld=%b busy=%b expected 0 0 0", state, res_valid, busy);
      end
   endtask

   task automatic test_reset_mid_run;
      a_in = 17'd1234;
      b_in = 17'd4321;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 6; i++) tick();
      n_tests++;
      if (state !== ST_RUN) begin
         n_fail++;
         $display("FAIL mid_run_state: st=%0d expected 2", state);
      end
      rst_n = 1'b0;
      #1;
      n_tests++;
      if (in_ready !== 1'b1 || res_valid !== 1'b0 || busy !== 1'b0 || res !== '0 ||
          state !== ST_IDLE) begin
         n_fail++;
         $display("FAIL async_reset: rdy=%b vld=%b busy=%b res=%h st=%0d expected 1 0 0 0 0",
                  in_ready, res_valid, busy, res, state);
      end
      #2;
      rst_n = 1'b1;
      tick();
      do_op(17'd7, 17'h1FFF7, 34'h3_FFFF_FFC1, "after_reset_7x-9");
   endtask

   task automatic test_back_to_back;
      logic [W-1:0]   ta [3];
      logic [W-1:0]   tb [3];
      logic [2*W-1:0] te [3];
      int last_acc;
      ta = '{17'd9, 17'h1FFF0, 17'd300};
      tb = '{17'd9, 17'd16,    17'h1FFFE};
      te = '{34'h0_0000_0051, 34'h3_FFFF_FF00, 34'h3_FFFF_FDA8};
      last_acc = 0;
      res_ready = 1'b1;
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         a_in = ta[i];
         b_in = tb[i];
         n_tests++;
         if (in_ready !== 1'b1 || (i > 0 && cyc - last_acc !== W + 3)) begin
            n_fail++;
            $display("FAIL b2b_accept[%0d]: rdy=%b gap=%0d expected 1 %0d",
                     i, in_ready, cyc - last_acc, W + 3);
         end
         last_acc = cyc;
         tick();
         for (int k = 0; k < 40 && res_valid !== 1'b1; k++) tick();
         n_tests++;
         if (res !== te[i]) begin
            n_fail++;
            $display("FAIL b2b_result[%0d]: res=%h expected %h", i, res, te[i]);
         end
         tick();
      end
      in_valid = 1'b0;
      res_ready = 1'b0;
      tick();
   endtask

   task automatic test_random;
      logic signed [W-1:0]   ra;
      logic signed [W-1:0]   rb;
      logic signed [2*W-1:0] rp;
      for (int i = 0; i < 12; i++) begin
         ra = W'($urandom_range(0, (1 << W) - 1));
         rb = W'($urandom_range(0, (1 << W) - 1));
         rp = ra * rb;
         for (int g = $urandom_range(0, 3); g > 0; g--) tick();
         do_op(ra, rb, rp, "random");
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_directed();
      test_adder_ports();
      test_backpressure();
      test_reset_mid_run();
      test_back_to_back();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
